// File: rtl/ccd_timing_gen_if.sv
// ccd_timing_gen_if: control/config inputs and CCD pad/ADC outputs of the timing generator.
interface ccd_timing_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16,
    parameter int PIX_W = 12
);
    logic             enable;
    logic             continuous;
    logic             start;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_rog_len;
    logic [CNT_W-1:0] cfg_sh_start;
    logic [CNT_W-1:0] cfg_sh_len;
    logic [CNT_W-1:0] cfg_frame_len;
    logic [PIX_W-1:0] cfg_num_pix;
    logic             phi1;
    logic             phi2;
    logic             rog;
    logic             sh;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_idx;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
    logic             cfg_err;

    modport master (
        output enable, continuous, start, cfg_div, cfg_rog_len, cfg_sh_start,
               cfg_sh_len, cfg_frame_len, cfg_num_pix,
        input  phi1, phi2, rog, sh, pix_valid, pix_idx, frame_start, frame_done,
               busy, cfg_err
    );

    modport slave (
        input  enable, continuous, start, cfg_div, cfg_rog_len, cfg_sh_start,
               cfg_sh_len, cfg_frame_len, cfg_num_pix,
        output phi1, phi2, rog, sh, pix_valid, pix_idx, frame_start, frame_done,
               busy, cfg_err
    );
endinterface

// File: rtl/ccd_timing_gen.sv
// ccd_timing_gen: CCD shift clocks, ROG/SH gates and pixel strobe from shadowed run-time config.
// Config is latched on entry to RUN and at each frame wrap; all outputs are registered.
module ccd_timing_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16,
    parameter int PIX_W = 12
) (
    input logic             clk,
    input logic             rst_n,
    ccd_timing_gen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_next;
    logic [DIV_W-1:0] r_div, r_div_cnt;
    logic [CNT_W-1:0] r_rog_len, r_sh_start, r_frame_len, r_frame_cnt;
    logic [CNT_W:0]   r_sh_end, w_sh_end;
    logic [PIX_W-1:0] r_num_pix, r_pix_cnt, r_pix_idx;
    logic             r_phi1, r_phi2, r_rog, r_sh, r_pix_valid;
    logic             r_frame_start, r_frame_done, r_busy, r_cfg_err;
    logic             w_cfg_ok, w_run, w_last, w_div_term, w_strobe;
    logic             w_load, w_rej, w_phi1_nxt;

    // SH end is one bit wider so start+len can never wrap past the frame length
    assign w_sh_end   = {1'b0, bus.cfg_sh_start} + {1'b0, bus.cfg_sh_len};
    assign w_cfg_ok   = (bus.cfg_div != '0) && (bus.cfg_rog_len != '0) &&
                        (bus.cfg_frame_len > bus.cfg_rog_len) &&
                        ({1'b0, bus.cfg_frame_len} > w_sh_end);
    assign w_run      = r_state == RUN;
    assign w_last     = r_frame_cnt == r_frame_len - CNT_W'(1);
    assign w_div_term = r_div_cnt >= r_div - DIV_W'(1);
    assign w_strobe   = w_run && w_div_term && !r_phi1 &&
                        (r_frame_cnt >= r_rog_len) && (r_pix_cnt < r_num_pix);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_rej  = 1'b0;
        if (!w_run) begin
            w_load = bus.start && bus.enable && w_cfg_ok;
            w_rej  = bus.start && bus.enable && !w_cfg_ok;
            w_next = w_load ? RUN : IDLE;
        end else if (w_last) begin
            w_load = bus.continuous && bus.enable && w_cfg_ok;
            w_rej  = bus.continuous && bus.enable && !w_cfg_ok;
            w_next = w_load ? RUN : IDLE;
        end
    end

    // Leaving RUN parks the shift clocks at phi1=0 on the exit edge
    assign w_phi1_nxt = (w_next == IDLE) ? 1'b0 : (w_run && w_div_term) ? !r_phi1 : r_phi1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_rog_len     <= '0;
            r_sh_start    <= '0;
            r_sh_end      <= '0;
            r_frame_len   <= '0;
            r_num_pix     <= '0;
            r_div_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_pix_cnt     <= '0;
            r_pix_idx     <= '0;
            r_phi1        <= 1'b0;
            r_phi2        <= 1'b1;
            r_rog         <= 1'b0;
            r_sh          <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            if (w_load) begin
                r_div       <= bus.cfg_div;
                r_rog_len   <= bus.cfg_rog_len;
                r_sh_start  <= bus.cfg_sh_start;
                r_sh_end    <= w_sh_end;
                r_frame_len <= bus.cfg_frame_len;
                r_num_pix   <= bus.cfg_num_pix;
            end
            r_cfg_err     <= w_rej ? 1'b1 : w_load ? 1'b0 : r_cfg_err;
            r_div_cnt     <= (!w_run || w_div_term) ? '0 : r_div_cnt + DIV_W'(1);
            r_frame_cnt   <= (!w_run || w_last) ? '0 : r_frame_cnt + CNT_W'(1);
            r_pix_cnt     <= (!w_run || w_last) ? '0 : r_pix_cnt + PIX_W'(w_strobe);
            r_pix_idx     <= w_strobe ? r_pix_cnt : r_pix_idx;
            r_pix_valid   <= w_strobe;
            r_phi1        <= w_phi1_nxt;
            r_phi2        <= !w_phi1_nxt;
            r_rog         <= w_run && (w_next == RUN) && (r_frame_cnt < r_rog_len);
            r_sh          <= w_run && (w_next == RUN) && (r_frame_cnt >= r_sh_start) &&
                             ({1'b0, r_frame_cnt} < r_sh_end);
            r_frame_start <= w_run && (r_frame_cnt == '0);
            r_frame_done  <= w_run && w_last;
            r_busy        <= w_next == RUN;
        end
    end

    assign bus.phi1        = r_phi1;
    assign bus.phi2        = r_phi2;
    assign bus.rog         = r_rog;
    assign bus.sh          = r_sh;
    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_idx     = r_pix_idx;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_done  = r_frame_done;
    assign bus.busy        = r_busy;
    assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_ccd_timing_gen.sv
// tb_ccd_timing_gen: directed scenarios; expected pulse cycles are queued at stimulus time
// and a negedge monitor matches every frame_start/pix_valid/frame_done against them.
module tb_ccd_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fs_q[$], fd_q[$], px_q[$], pi_q[$];

    ccd_timing_gen_if #(.DIV_W(8), .CNT_W(16), .PIX_W(12)) bus ();
    ccd_timing_gen #(.DIV_W(8), .CNT_W(16), .PIX_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic push_frame(input int e, input int k, input int npix);
        fs_q.push_back(e + 1 + 40 * k);
        for (int j = 0; j < npix; j++) begin
            px_q.push_back(e + 6 + 40 * k + 4 * j);
            pi_q.push_back(j);
        end
        fd_q.push_back(e + 40 + 40 * k);
    endtask

    // Scoreboard monitor: report missed pulses, then match any pulse seen this cycle
    always @(negedge clk) begin
        int t;
        if (fs_q.size() != 0 && fs_q[0] < cyc) begin
            t = fs_q.pop_front(); n_cmp++; n_bad++;
            $display("FAIL frame_start: got no pulse, want pulse at cyc %0d", t);
        end
        if (fd_q.size() != 0 && fd_q[0] < cyc) begin
            t = fd_q.pop_front(); n_cmp++; n_bad++;
            $display("FAIL frame_done: got no pulse, want pulse at cyc %0d", t);
        end
        if (px_q.size() != 0 && px_q[0] < cyc) begin
            t = px_q.pop_front(); n_cmp++; n_bad++;
            $display("FAIL pix_valid: got no strobe, want strobe idx %0d at cyc %0d", pi_q.pop_front(), t);
        end
        if (bus.frame_start) begin
            n_cmp++;
            if (fs_q.size() != 0 && fs_q[0] == cyc) t = fs_q.pop_front();
            else begin
                n_bad++;
                $display("FAIL frame_start: got pulse at cyc %0d, want none", cyc);
            end
        end
        if (bus.frame_done) begin
            n_cmp++;
            if (fd_q.size() != 0 && fd_q[0] == cyc) t = fd_q.pop_front();
            else begin
                n_bad++;
                $display("FAIL frame_done: got pulse at cyc %0d, want none", cyc);
            end
        end
        if (bus.pix_valid) begin
            n_cmp++;
            if (px_q.size() != 0 && px_q[0] == cyc) begin
                t = px_q.pop_front();
                t = pi_q.pop_front();
                if (int'(bus.pix_idx) != t) begin
                    n_bad++;
                    $display("FAIL pix_idx @cyc %0d: got %0d, want %0d", cyc, bus.pix_idx, t);
                end
            end else begin
                n_bad++;
                $display("FAIL pix_valid: got strobe idx %0d at cyc %0d, want none", bus.pix_idx, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int s, e;
        bus.enable = 1'b1; bus.continuous = 1'b0; bus.start = 1'b0;
        bus.cfg_div = 8'd2; bus.cfg_rog_len = 16'd4; bus.cfg_sh_start = 16'd8;
        bus.cfg_sh_len = 16'd4; bus.cfg_frame_len = 16'd40; bus.cfg_num_pix = 12'd5;
        at(3);
        chk("rst_phi1", bus.phi1, 0);
        chk("rst_phi2", bus.phi2, 1);
        chk("rst_rog", bus.rog, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        rst_n = 1'b1;

        // single shot
        s = cyc + 2; e = s + 1;
        at(s); bus.start = 1'b1; push_frame(e, 0, 5);
        at(e); bus.start = 1'b0; chk("ss_busy_entry", bus.busy, 1);
        at(e + 1);  chk("ss_rog_first", bus.rog, 1); chk("ss_phi1_lo", bus.phi1, 0);
        at(e + 2);  chk("ss_phi1_rise", bus.phi1, 1); chk("ss_phi2_fall", bus.phi2, 0);
        at(e + 4);  chk("ss_rog_last", bus.rog, 1);
        at(e + 5);  chk("ss_rog_off", bus.rog, 0);
        at(e + 8);  chk("ss_sh_pre", bus.sh, 0);
        at(e + 9);  chk("ss_sh_first", bus.sh, 1);
        at(e + 12); chk("ss_sh_last", bus.sh, 1);
        at(e + 13); chk("ss_sh_off", bus.sh, 0);
        at(e + 39); chk("ss_busy_end", bus.busy, 1);
        at(e + 40); chk("ss_busy_idle", bus.busy, 0); chk("ss_phi1_idle", bus.phi1, 0);
        chk("ss_phi2_idle", bus.phi2, 1);

        // invalid config: sh_start+sh_len == frame_len
        s = e + 45;
        at(s); bus.cfg_frame_len = 16'd12; bus.start = 1'b1;
        at(s + 1); bus.start = 1'b0; chk("inv_cfg_err", bus.cfg_err, 1); chk("inv_busy", bus.busy, 0);
        at(s + 5); chk("inv_cfg_err_sticky", bus.cfg_err, 1); chk("inv_busy_hold", bus.busy, 0);

        // continuous, mid-frame sh_start change, enable drop, start while busy
        s = s + 8; e = s + 1;
        at(s); bus.cfg_frame_len = 16'd40; bus.continuous = 1'b1; bus.start = 1'b1;
        for (int k = 0; k < 3; k++) push_frame(e, k, 5);
        at(e); bus.start = 1'b0; chk("ct_cfg_err_clr", bus.cfg_err, 0); chk("ct_busy", bus.busy, 1);
        at(e + 9);  chk("ct_sh_f0", bus.sh, 1);
        at(e + 20); bus.cfg_sh_start = 16'd20;
        at(e + 21); chk("ct_sh_shadowed", bus.sh, 0);
        at(e + 39); chk("ct_phi1_prewrap", bus.phi1, 1);
        at(e + 40); chk("ct_phi1_wrap", bus.phi1, 0); chk("ct_busy_wrap", bus.busy, 1);
        at(e + 42); chk("ct_phi1_postwrap", bus.phi1, 1);
        at(e + 44); chk("ct_rog_f1", bus.rog, 1);
        at(e + 45); chk("ct_rog_f1_off", bus.rog, 0);
        at(e + 60); chk("ct_sh_new_pre", bus.sh, 0);
        at(e + 61); chk("ct_sh_new_first", bus.sh, 1);
        at(e + 64); chk("ct_sh_new_last", bus.sh, 1);
        at(e + 65); chk("ct_sh_new_off", bus.sh, 0);
        at(e + 90); bus.enable = 1'b0;
        at(e + 100); bus.start = 1'b1;
        at(e + 101); bus.start = 1'b0;
        at(e + 119); chk("ct_busy_last", bus.busy, 1);
        at(e + 120); chk("ct_busy_stop", bus.busy, 0); chk("ct_phi1_stop", bus.phi1, 0);

        // num_pix beyond what fits: 9 strobes per frame, index restarts
        s = e + 125; e = s + 1;
        at(s); bus.enable = 1'b1; bus.cfg_num_pix = 12'd100; bus.cfg_sh_start = 16'd8; bus.start = 1'b1;
        for (int k = 0; k < 2; k++) push_frame(e, k, 9);
        at(e); bus.start = 1'b0;
        at(e + 39); chk("np_idx_hold", bus.pix_idx, 8); chk("np_no_strobe", bus.pix_valid, 0);
        at(e + 45); chk("np_idx_hold_wrap", bus.pix_idx, 8);
        at(e + 46); chk("np_idx_restart", bus.pix_idx, 0);
        at(e + 60); bus.enable = 1'b0;
        at(e + 80); chk("np_busy_stop", bus.busy, 0);

        // async reset mid-readout
        s = e + 85; e = s + 1;
        at(s); bus.enable = 1'b1; bus.continuous = 1'b0; bus.cfg_num_pix = 12'd5; bus.start = 1'b1;
        fs_q.push_back(e + 1);
        for (int j = 0; j < 3; j++) begin
            px_q.push_back(e + 6 + 4 * j);
            pi_q.push_back(j);
        end
        at(e); bus.start = 1'b0;
        at(e + 15); chk("ar_pre_phi1", bus.phi1, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_phi1", bus.phi1, 0);
        chk("ar_phi2", bus.phi2, 1);
        chk("ar_busy", bus.busy, 0);
        chk("ar_pix_idx", bus.pix_idx, 0);
        chk("ar_rog", bus.rog, 0);
        chk("ar_sh", bus.sh, 0);
        at(e + 18); rst_n = 1'b1;
        at(e + 20); chk("ar_post_busy", bus.busy, 0); chk("ar_post_phi2", bus.phi2, 1);
        at(e + 70); chk("ar_quiet_busy", bus.busy, 0); chk("ar_quiet_phi1", bus.phi1, 0);

        chk("left_frame_start", fs_q.size(), 0);
        chk("left_frame_done", fd_q.size(), 0);
        chk("left_pix", px_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ccd_timing_gen.md
Name: ccd_timing_gen

Overview:
- Parametrised CCD timing generator; next generation of the fixed-divider CCD clock block.
- Generates complementary shift clocks (phi1/phi2), ROG and SH pulses, and a per-pixel sample strobe with pixel index.
- Divider, window positions, frame length and pixel count come from run-time config inputs. These are shadow-latched at frame boundaries.
- Supports single-shot and continuous modes. Sits between the control/register block and the CCD pads/ADC capture logic.

Parameters:
- DIV_W, 8, width of cfg_div.
- CNT_W, 16, width of the frame counter and the window config fields.
- PIX_W, 12, width of cfg_num_pix and pix_idx.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run permission; low = stop at end of current frame
- continuous  in  1  1 = free-running frames, 0 = single shot
- start  in  1  one-cycle start request
- cfg_div  in  DIV_W  clk cycles per phi half-period (valid 1..2^DIV_W-1)
- cfg_rog_len  in  CNT_W  ROG width in clk cycles
- cfg_sh_start  in  CNT_W  SH start offset (frame_cnt value)
- cfg_sh_len  in  CNT_W  SH width in clk cycles
- cfg_frame_len  in  CNT_W  frame length in clk cycles
- cfg_num_pix  in  PIX_W  pixels read out per frame
- phi1  out  1  shift clock 1
- phi2  out  1  shift clock 2, always ~phi1
- rog  out  1  ROG gate
- sh  out  1  SH gate
- pix_valid  out  1  one-cycle pixel sample strobe
- pix_idx  out  PIX_W  index of the current pixel, valid with pix_valid
- frame_start  out  1  one-cycle pulse at frame_cnt=0
- frame_done  out  1  one-cycle pulse after the last frame cycle
- busy  out  1  high in RUN
- cfg_err  out  1  sticky config rejection flag

Behaviour:
- Reset and IDLE values: phi1=0, phi2=1, all other outputs 0; div_cnt=0, frame_cnt=0, pix_cnt=0; state IDLE.
- Config check, combinational on the live cfg_* inputs. The config is valid iff all of the following hold:
  - cfg_div≥1
  - cfg_rog_len≥1
  - cfg_frame_len > cfg_rog_len
  - cfg_frame_len > cfg_sh_start+cfg_sh_len, with the sum computed at CNT_W+1 bits so it cannot wrap
- States:
  - IDLE: start&enable&valid → latch all cfg into shadow registers, clear cfg_err, go RUN with frame_cnt=0, div_cnt=0. start&enable&!valid → cfg_err=1, stay IDLE.
  - RUN: frame_cnt increments every clk. At frame_cnt==frame_len-1, wrap to 0 and clear pix_cnt. Then:
    - continuous&enable&valid → reload shadows, stay RUN.
    - continuous&enable&!valid → cfg_err=1, go IDLE.
    - otherwise → go IDLE.
- Start is ignored in RUN. Config changes mid-frame have no effect until the next frame boundary.
- All outputs are registered from the current counter/state values: 1-cycle latency.
  - rog = RUN & frame_cnt<rog_len.
  - sh = RUN & sh_start≤frame_cnt<sh_start+sh_len.
  - frame_start when entering RUN or wrapping into a new frame.
  - frame_done on every wrap.
  - busy = RUN.
- Divider, RUN only: div_cnt counts 0..div-1. At terminal it returns to 0 and phi1/phi2 toggle. The divider is not reset at frame wrap (continuous clocking); it is reset only on entry from IDLE.
- Pixel strobe: in the cycle where div is at terminal, phi1==0 (rising toggle), frame_cnt≥rog_len and pix_cnt<num_pix, register pix_valid=1 and pix_idx=pix_cnt, then pix_cnt+1. pix_idx holds between strobes. Pixels not reached before frame end are dropped.
- Entering IDLE from RUN forces phi1=0, phi2=1, rog=0, sh=0 on the same edge.
- Async reset mid-frame returns everything to reset values immediately.
- Width rules: frame_cnt is CNT_W bits. Comparisons are unsigned. sh_start+sh_len is computed at CNT_W+1 bits.

Test Plan:
- Single shot: div=2, rog_len=4, sh_start=8, sh_len=4, frame_len=40, num_pix=5, start pulse at cycle S, entry cycle E=S+1.
  - Required response: frame_start@E+1; rog high E+1..E+4; sh high E+9..E+12; phi1 rises E+2,E+6,…
  - pix_valid@E+6,E+10,E+14,E+18,E+22 with pix_idx 0..4.
  - frame_done@E+40, then busy=0, phi1=0, phi2=1.
- Continuous, same config: frame_start every 40 cycles, 5 strobes per frame with pix_idx restarting at 0, phi never stalls at the wrap. Change cfg_sh_start to 20 mid-frame → the next frame's sh is high at frame_cnt+1 = 21..24.
- Invalid config: frame_len=12, sh_start=8, sh_len=4 → start rejected, cfg_err=1, busy stays 0. A following valid start clears cfg_err.
- enable dropped mid-frame in continuous mode → the current frame completes, frame_done fires, then IDLE. start while busy → no effect.
- num_pix larger than the window fits (num_pix=100, frame_len=40): strobes stop at frame end, pix_idx restarts at 0 next frame.
- rst_n asserted mid-readout → all outputs at reset values asynchronously; after release, state IDLE with no spurious pulses.
